// File: rtl/wb_sb_pkg.sv
// wb_sb_pkg: shared constants for the LC-3b writeback scoreboard.
package wb_sb_pkg;
  localparam int SB_CNT_W = 2;
  localparam int SB_NUM_REGS = 8;
  localparam int SR_CS_LD_CC = 3;
  localparam int SR_CS_LD_REG = 2;
  localparam int SR_CS_VALUEMUX_HI = 1;
  localparam int SR_CS_VALUEMUX_LO = 0;
  typedef enum logic [1:0] {
    VM_ADDR = 2'd0,
    VM_DATA = 2'd1,
    VM_NPC  = 2'd2,
    VM_ALU  = 2'd3
  } valuemux_e;
endpackage

// File: rtl/wb_sb_counter.sv
// wb_sb_counter: saturating up/down pending-write counter with overflow/underflow event flags.
import wb_sb_pkg::*;

module wb_sb_counter #(
  parameter int CNT_W = SB_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             ovf,
  output logic             udf
);
  localparam logic [CNT_W-1:0] MAX = '1;
  assign ovf = inc & ~dec & (count == MAX);
  assign udf = dec & ~inc & (count == '0);
  always_ff @(posedge clk)
    if (!rst_n) count <= '0;
    else if (inc & ~dec & ~ovf) count <= count + 1'b1;
    else if (dec & ~inc & ~udf) count <= count - 1'b1;
endmodule

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: register/CC dependency tracker raising DE stalls for LC-3b.
// WB_SCOREBOARD_BYPASS_EN releases a stall in the retire cycle itself.
import wb_sb_pkg::*;

module wb_scoreboard #(
  parameter int CNT_W = SB_CNT_W,
  parameter int NUM_REGS = SB_NUM_REGS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                issue_v,
  input  logic                issue_ld_reg,
  input  logic                issue_ld_cc,
  input  logic [2:0]          issue_drid,
  input  logic [2:0]          de_sr1,
  input  logic                de_sr1_needed,
  input  logic [2:0]          de_sr2,
  input  logic                de_sr2_needed,
  input  logic                de_br_op,
  input  logic                de_v,
  input  logic                v_sr_ld_reg,
  input  logic                v_sr_ld_cc,
  input  logic [2:0]          sr_drid,
  output logic                dep_stall,
  output logic                cc_stall,
  output logic [NUM_REGS-1:0] reg_pending,
  output logic                cc_pending,
  output logic                err_overflow,
  output logic                err_underflow
);
  // index NUM_REGS is the condition-code counter
  logic [NUM_REGS:0] inc, dec, ovf, udf, pend;
  logic [CNT_W-1:0] cnt [NUM_REGS+1];
  for (genvar i = 0; i <= NUM_REGS; i++) begin : g_cnt
    if (i < NUM_REGS) begin : g_reg
      assign inc[i] = issue_v & issue_ld_reg & (issue_drid == 3'(i));
      assign dec[i] = v_sr_ld_reg & (sr_drid == 3'(i));
      assign reg_pending[i] = |cnt[i];
    end else begin : g_cc
      assign inc[i] = issue_v & issue_ld_cc;
      assign dec[i] = v_sr_ld_cc;
    end
`ifdef WB_SCOREBOARD_BYPASS_EN
    assign pend[i] = (|cnt[i]) & ~((cnt[i] == CNT_W'(1)) & dec[i]);
`else
    assign pend[i] = |cnt[i];
`endif
    wb_sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk(clk), .rst_n(rst_n), .inc(inc[i]), .dec(dec[i]),
      .count(cnt[i]), .ovf(ovf[i]), .udf(udf[i])
    );
  end
  assign cc_pending = |cnt[NUM_REGS];
  assign dep_stall = de_v & ((de_sr1_needed & pend[de_sr1]) | (de_sr2_needed & pend[de_sr2]));
  assign cc_stall = de_v & de_br_op & pend[NUM_REGS];
  always_ff @(posedge clk)
    if (!rst_n) begin
      err_overflow <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      err_overflow <= err_overflow | (|ovf);
      err_underflow <= err_underflow | (|udf);
    end
endmodule

// File: tb/tb_wb_scoreboard.sv
// tb_wb_scoreboard: vector table, corner sequences and randomized run against a counting model.
module tb_wb_scoreboard;
  localparam int MAXC = 3;
`ifdef WB_SCOREBOARD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 0, rst_n = 0;
  logic issue_v = 0, issue_ld_reg = 0, issue_ld_cc = 0;
  logic [2:0] issue_drid = 0, de_sr1 = 0, de_sr2 = 0, sr_drid = 0;
  logic de_sr1_needed = 0, de_sr2_needed = 0, de_br_op = 0, de_v = 0;
  logic v_sr_ld_reg = 0, v_sr_ld_cc = 0;
  logic dep_stall, cc_stall, cc_pending, err_overflow, err_underflow;
  logic [7:0] reg_pending;
  int errors = 0, checks = 0;
  int m [9];
  bit m_ovf, m_udf;
  logic got_dep, got_ccs;

  wb_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .issue_v(issue_v), .issue_ld_reg(issue_ld_reg),
    .issue_ld_cc(issue_ld_cc), .issue_drid(issue_drid), .de_sr1(de_sr1),
    .de_sr1_needed(de_sr1_needed), .de_sr2(de_sr2), .de_sr2_needed(de_sr2_needed),
    .de_br_op(de_br_op), .de_v(de_v), .v_sr_ld_reg(v_sr_ld_reg), .v_sr_ld_cc(v_sr_ld_cc),
    .sr_drid(sr_drid), .dep_stall(dep_stall), .cc_stall(cc_stall),
    .reg_pending(reg_pending), .cc_pending(cc_pending),
    .err_overflow(err_overflow), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit pend_m(input int r, input bit retiring);
    return m[r] != 0 && !(BYP && m[r] == 1 && retiring);
  endfunction

  // drives nothing: checks stalls for current inputs, clocks, then checks model state
  task automatic cycle();
    bit ed, ec;
    logic [7:0] ep;
    ed = de_v && ((de_sr1_needed && pend_m(int'(de_sr1), v_sr_ld_reg && sr_drid == de_sr1)) ||
                  (de_sr2_needed && pend_m(int'(de_sr2), v_sr_ld_reg && sr_drid == de_sr2)));
    ec = de_v && de_br_op && pend_m(8, v_sr_ld_cc);
    #2;
    got_dep = dep_stall;
    got_ccs = cc_stall;
    chk("dep_stall", {31'd0, dep_stall}, {31'd0, ed});
    chk("cc_stall", {31'd0, cc_stall}, {31'd0, ec});
    @(posedge clk);
    if (!rst_n) begin
      foreach (m[k]) m[k] = 0;
      m_ovf = 0;
      m_udf = 0;
    end else begin
      for (int k = 0; k < 9; k++) begin
        bit inc, dec;
        inc = issue_v && (k < 8 ? (issue_ld_reg && int'(issue_drid) == k) : issue_ld_cc);
        dec = k < 8 ? (v_sr_ld_reg && int'(sr_drid) == k) : v_sr_ld_cc;
        if (inc && !dec) begin
          if (m[k] == MAXC) m_ovf = 1; else m[k]++;
        end else if (dec && !inc) begin
          if (m[k] == 0) m_udf = 1; else m[k]--;
        end
      end
    end
    #1;
    for (int k = 0; k < 8; k++) ep[k] = m[k] != 0;
    chk("reg_pending", {24'd0, reg_pending}, {24'd0, ep});
    chk("cc_pending", {31'd0, cc_pending}, {31'd0, m[8] != 0});
    chk("err_overflow", {31'd0, err_overflow}, {31'd0, m_ovf});
    chk("err_underflow", {31'd0, err_underflow}, {31'd0, m_udf});
  endtask

  task automatic idle_inputs();
    issue_v = 0; issue_ld_reg = 0; issue_ld_cc = 0; issue_drid = 0;
    de_sr1 = 0; de_sr1_needed = 0; de_sr2 = 0; de_sr2_needed = 0; de_br_op = 0; de_v = 0;
    v_sr_ld_reg = 0; v_sr_ld_cc = 0; sr_drid = 0;
  endtask

  typedef struct {
    logic iv, lr, lc; logic [2:0] drid, s1; logic s1n, br, dv, vr, vc; logic [2:0] srid;
    logic [7:0] ep; logic ecp, ed, ecs, eu;
  } vec_t;
  vec_t tab [18];

  initial begin
    foreach (m[k]) m[k] = 0;
    m_ovf = 0;
    m_udf = 0;
    tab[0]  = '{1,1,1,3, 0,0,0,0, 0,0,0, 8'h08,1,0,0,0};
    tab[1]  = '{0,0,0,0, 3,1,0,1, 0,0,0, 8'h08,1,1,0,0};
    tab[2]  = '{0,0,0,0, 3,1,0,1, 0,0,0, 8'h08,1,1,0,0};
    tab[3]  = '{0,0,0,0, 3,1,0,1, 1,1,3, 8'h00,0,!BYP,0,0};
    tab[4]  = '{0,0,0,0, 3,1,0,1, 0,0,0, 8'h00,0,0,0,0};
    tab[5]  = '{1,0,1,0, 0,0,1,1, 0,0,0, 8'h00,1,0,0,0};
    tab[6]  = '{0,0,0,0, 0,0,1,1, 0,0,0, 8'h00,1,0,1,0};
    tab[7]  = '{0,0,0,0, 0,0,1,1, 0,1,0, 8'h00,0,0,!BYP,0};
    tab[8]  = '{1,1,0,5, 0,0,0,0, 0,0,0, 8'h20,0,0,0,0};
    tab[9]  = '{1,1,0,5, 0,0,0,0, 0,0,0, 8'h20,0,0,0,0};
    tab[10] = '{1,1,0,5, 0,0,0,0, 0,0,0, 8'h20,0,0,0,0};
    tab[11] = '{0,0,0,0, 0,0,0,0, 1,0,5, 8'h20,0,0,0,0};
    tab[12] = '{0,0,0,0, 0,0,0,0, 1,0,5, 8'h20,0,0,0,0};
    tab[13] = '{0,0,0,0, 0,0,0,0, 1,0,5, 8'h00,0,0,0,0};
    tab[14] = '{1,1,0,2, 0,0,0,0, 0,0,0, 8'h04,0,0,0,0};
    tab[15] = '{1,1,0,2, 0,0,0,0, 1,0,2, 8'h04,0,0,0,0};
    tab[16] = '{0,0,0,0, 0,0,0,0, 1,0,2, 8'h00,0,0,0,0};
    tab[17] = '{0,0,0,0, 0,0,0,0, 1,0,7, 8'h00,0,0,0,1};

    @(posedge clk);
    #1;
    cycle();
    rst_n = 1;
    for (int i = 0; i < 5; i++) cycle();
    chk("idle_pending", {24'd0, reg_pending}, 32'h0);

    foreach (tab[i]) begin
      issue_v = tab[i].iv; issue_ld_reg = tab[i].lr; issue_ld_cc = tab[i].lc; issue_drid = tab[i].drid;
      de_sr1 = tab[i].s1; de_sr1_needed = tab[i].s1n; de_sr2 = 0; de_sr2_needed = 0;
      de_br_op = tab[i].br; de_v = tab[i].dv;
      v_sr_ld_reg = tab[i].vr; v_sr_ld_cc = tab[i].vc; sr_drid = tab[i].srid;
      cycle();
      chk("tab_dep", {31'd0, got_dep}, {31'd0, tab[i].ed});
      chk("tab_cc_stall", {31'd0, got_ccs}, {31'd0, tab[i].ecs});
      chk("tab_pend", {24'd0, reg_pending}, {24'd0, tab[i].ep});
      chk("tab_cc_pend", {31'd0, cc_pending}, {31'd0, tab[i].ecp});
      chk("tab_udf", {31'd0, err_underflow}, {31'd0, tab[i].eu});
      chk("tab_ovf", {31'd0, err_overflow}, 32'd0);
    end
    idle_inputs();

    rst_n = 0;
    cycle();
    rst_n = 1;
    chk("rst_clears_udf", {31'd0, err_underflow}, 32'd0);

    // self-dependency: issuing R1 while DE reads R1 must not stall
    issue_v = 1; issue_ld_reg = 1; issue_drid = 1;
    de_v = 1; de_sr1 = 1; de_sr1_needed = 1; de_sr2 = 1; de_sr2_needed = 1;
    cycle();
    chk("self_dep", {31'd0, got_dep}, 32'd0);
    idle_inputs();
    v_sr_ld_reg = 1; sr_drid = 1;
    cycle();
    idle_inputs();

    issue_v = 1; issue_ld_reg = 1; issue_drid = 5;
    for (int i = 0; i < 4; i++) cycle();
    chk("ovf_set", {31'd0, err_overflow}, 32'd1);
    idle_inputs();
    for (int i = 0; i < 3; i++) cycle();
    chk("ovf_sticky", {31'd0, err_overflow}, 32'd1);
    v_sr_ld_reg = 1; sr_drid = 5;
    cycle();
    cycle();
    chk("sat_held_3", {24'd0, reg_pending}, 32'h20);
    cycle();
    chk("sat_drained", {24'd0, reg_pending}, 32'h00);
    chk("no_udf", {31'd0, err_underflow}, 32'd0);
    idle_inputs();
    rst_n = 0;
    cycle();
    rst_n = 1;
    chk("rst_clears_ovf", {31'd0, err_overflow}, 32'd0);

    for (int i = 0; i < 600; i++) begin
      rst_n = $urandom_range(0, 59) != 0;
      issue_v = $urandom_range(0, 1);
      issue_ld_reg = $urandom_range(0, 3) != 0;
      issue_ld_cc = $urandom_range(0, 1);
      issue_drid = 3'($urandom_range(0, 7));
      de_sr1 = 3'($urandom_range(0, 7));
      de_sr2 = 3'($urandom_range(0, 7));
      de_sr1_needed = $urandom_range(0, 1);
      de_sr2_needed = $urandom_range(0, 1);
      de_br_op = $urandom_range(0, 1);
      de_v = $urandom_range(0, 3) != 0;
      v_sr_ld_reg = $urandom_range(0, 1);
      v_sr_ld_cc = $urandom_range(0, 2) == 0;
      sr_drid = 3'($urandom_range(0, 7));
      cycle();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
